lcd_hex_writer: RTL and testbench

Formatting stage between the CH7301 config/readback logic and the wb_lcd character controller.
- Accepts {register address, register data, slot} records on a valid/ready handshake.
- Renders each record as 4 uppercase hex ASCII characters into the LCD character RAM through a Wishbone master.
- Then issues a repaint command once the LCD core is not busy.
- Also supports a full-screen clear. Frees the control FSM from character-level LCD sequencing.

---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_hex_writer_if.sv | 30 +++
 rtl/hex_ascii.sv | 9 +
 rtl/lcd_hex_writer.sv | 183 ++++++++++++++++++
 tb/tb_lcd_hex_writer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and hex formatting for the LCD character writer.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_ADDR    = 8'h80;
  localparam logic [7:0] LCD_CMD_REPAINT = 8'h01;
  localparam logic [7:0] LCD_CHAR_SPACE  = 8'h20;
  localparam int unsigned LCD_NUM_CHARS  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWaitAck,
    StBusyWait,
    StRepaint,
    StRepaintAck
  } lcd_state_e;

  // Uppercase ASCII for one hex digit.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/lcd_hex_writer_if.sv
// Record handshake plus Wishbone master bus of the LCD hex writer.
interface lcd_hex_writer_if;
  logic        clear_req;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_slot;
  logic [7:0]  req_reg_addr;
  logic [7:0]  req_data;
  logic        done;
  logic        err;
  logic [7:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic [31:0] wb_dat_i;

  // Writer side: accepts records, masters the LCD bus.
  modport master (
    input  clear_req, req_valid, req_slot, req_reg_addr, req_data, wb_ack_i, wb_dat_i,
    output req_ready, done, err, wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

  // Environment side: record producer and LCD slave.
  modport slave (
    output clear_req, req_valid, req_slot, req_reg_addr, req_data, wb_ack_i, wb_dat_i,
    input  req_ready, done, err, wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/hex_ascii.sv
// Combinational nibble to uppercase hex ASCII converter.
module hex_ascii
  import lcd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);
  assign o_ascii = hex_to_ascii(i_nibble);
endmodule

// File: rtl/lcd_hex_writer.sv
// Renders {reg addr, data} records or a full clear into LCD char RAM, then repaints.
module lcd_hex_writer
  import lcd_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned SLOT_CHARS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  lcd_hex_writer_if.master  bus
);

  localparam int unsigned    CntW    = $clog2(ACK_TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);
  localparam logic [4:0]     LastRec = 5'(SLOT_CHARS - 1);
  localparam logic [4:0]     LastClr = 5'(LCD_NUM_CHARS - 1);

  lcd_state_e      r_state, w_state_d;
  logic            r_clear, w_clear_d;
  logic [2:0]      r_slot, w_slot_d;
  logic [7:0]      r_reg, w_reg_d;
  logic [7:0]      r_data, w_data_d;
  logic [4:0]      r_idx, w_idx_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [7:0]      r_adr, w_adr_d;
  logic [7:0]      r_dat, w_dat_d;
  logic            r_cyc, w_cyc_d;
  logic            r_we, w_we_d;
  logic            r_done, w_done_d;
  logic            r_err, w_err_d;

  logic [3:0] w_nibble;
  logic [7:0] w_ascii;
  logic [7:0] w_char_adr;
  logic [7:0] w_char_dat;
  logic       w_last;
  logic       w_unused;

  assign w_unused = ^bus.wb_dat_i[31:1];

  always_comb begin
    case (r_idx[1:0])
      2'd0:    w_nibble = r_reg[7:4];
      2'd1:    w_nibble = r_reg[3:0];
      2'd2:    w_nibble = r_data[7:4];
      default: w_nibble = r_data[3:0];
    endcase
  end

  hex_ascii u_hex_ascii (
    .i_nibble (w_nibble),
    .o_ascii  (w_ascii)
  );

  assign w_char_adr = r_clear ? {3'b000, r_idx} : {3'b000, r_slot, r_idx[1:0]};
  assign w_char_dat = r_clear ? LCD_CHAR_SPACE : w_ascii;
  assign w_last     = r_clear ? (r_idx == LastClr) : (r_idx == LastRec);

  assign bus.req_ready = (r_state == StIdle) & ~bus.clear_req & ~reset;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.wb_adr_o  = r_adr;
  assign bus.wb_dat_o  = r_dat;
  assign bus.wb_we_o   = r_we;
  assign bus.wb_cyc_o  = r_cyc;
  assign bus.wb_stb_o  = r_cyc;

  always_comb begin
    w_state_d = r_state;
    w_clear_d = r_clear;
    w_slot_d  = r_slot;
    w_reg_d   = r_reg;
    w_data_d  = r_data;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    w_adr_d   = r_adr;
    w_dat_d   = r_dat;
    w_cyc_d   = r_cyc;
    w_we_d    = r_we;
    w_done_d  = 1'b0;
    w_err_d   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.clear_req) begin
          w_clear_d = 1'b1;
          w_idx_d   = '0;
          w_state_d = StWr;
        end else if (bus.req_valid) begin
          w_clear_d = 1'b0;
          w_slot_d  = bus.req_slot;
          w_reg_d   = bus.req_reg_addr;
          w_data_d  = bus.req_data;
          w_idx_d   = '0;
          w_state_d = StWr;
        end
      end
      StWr: begin
        w_adr_d   = w_char_adr;
        w_dat_d   = w_char_dat;
        w_cyc_d   = 1'b1;
        w_we_d    = 1'b1;
        w_cnt_d   = '0;
        w_state_d = StWaitAck;
      end
      StWaitAck: begin
        // An ack in the expiring cycle still completes the access.
        if (bus.wb_ack_i) begin
          w_cyc_d   = 1'b0;
          w_we_d    = 1'b0;
          w_idx_d   = r_idx + 5'd1;
          w_state_d = w_last ? StBusyWait : StWr;
        end else if (r_cnt == CntMax) begin
          w_cyc_d   = 1'b0;
          w_we_d    = 1'b0;
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StBusyWait: begin
        if (!bus.wb_dat_i[0]) w_state_d = StRepaint;
      end
      StRepaint: begin
        w_adr_d   = LCD_CMD_ADDR;
        w_dat_d   = LCD_CMD_REPAINT;
        w_cyc_d   = 1'b1;
        w_we_d    = 1'b1;
        w_cnt_d   = '0;
        w_state_d = StRepaintAck;
      end
      StRepaintAck: begin
        if (bus.wb_ack_i) begin
          w_cyc_d   = 1'b0;
          w_we_d    = 1'b0;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end else if (r_cnt == CntMax) begin
          w_cyc_d   = 1'b0;
          w_we_d    = 1'b0;
          w_err_d   = 1'b1;
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_clear <= 1'b0;
      r_slot  <= '0;
      r_reg   <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_clear <= w_clear_d;
      r_slot  <= w_slot_d;
      r_reg   <= w_reg_d;
      r_data  <= w_data_d;
      r_idx   <= w_idx_d;
      r_cnt   <= w_cnt_d;
      r_adr   <= w_adr_d;
      r_dat   <= w_dat_d;
      r_cyc   <= w_cyc_d;
      r_we    <= w_we_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
    end
  end

endmodule

// File: tb/tb_lcd_hex_writer.sv
// Directed bench for lcd_hex_writer with a logging Wishbone slave model.
module tb_lcd_hex_writer;

  logic clk;
  logic reset;
  logic busy;
  logic ack_en;
  logic [7:0] nack_adr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] log_adr [0:255];
  logic [7:0] log_dat [0:255];
  int log_n   = 0;
  int n_done  = 0;
  int n_errp  = 0;
  int n_stall = 0;

  lcd_hex_writer_if ifc ();

  lcd_hex_writer #(
    .ACK_TIMEOUT (16),
    .SLOT_CHARS  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  // Slave acks every access immediately except the one at nack_adr.
  assign ifc.wb_ack_i = ifc.wb_cyc_o & ack_en & (ifc.wb_adr_o != nack_adr);
  assign ifc.wb_dat_i = {31'b0, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifc.wb_cyc_o && ifc.wb_ack_i && log_n < 256) begin
      log_adr[log_n] = ifc.wb_adr_o;
      log_dat[log_n] = ifc.wb_dat_o;
      log_n = log_n + 1;
    end
    if (ifc.done) n_done = n_done + 1;
    if (ifc.err) n_errp = n_errp + 1;
    if (ifc.wb_cyc_o && ifc.wb_adr_o == 8'h0E) n_stall = n_stall + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the capture edge.
  task automatic send_rec(input string tag, input logic [2:0] slot, input logic [7:0] ra,
                          input logic [7:0] rd);
    #1;
    chk({tag, "_ready"}, ifc.req_ready, 1'b1);
    ifc.req_slot     = slot;
    ifc.req_reg_addr = ra;
    ifc.req_data     = rd;
    ifc.req_valid    = 1'b1;
    @(negedge clk);
    ifc.req_valid    = 1'b0;
  endtask

  task automatic wait_flag(input int max, input bit want_err, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (want_err ? ifc.err : ifc.done) return;
    end
    n = -1;
  endtask

  task automatic chk_rec(input string tag, input int base, input logic [7:0] adr0,
                         input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] d3);
    logic [7:0] exp_d [0:3];
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_adr%0d", tag, k), log_adr[base+k], adr0 + 8'(k));
      chk($sformatf("%s_dat%0d", tag, k), log_dat[base+k], exp_d[k]);
    end
    chk({tag, "_rp_adr"}, log_adr[base+4], 8'h80);
    chk({tag, "_rp_dat"}, log_dat[base+4], 8'h01);
  endtask

  initial begin
    int n;
    int base;
    int dbase;
    int rdy;
    reset = 1'b1;
    busy = 1'b0;
    ack_en = 1'b1;
    nack_adr = 8'hFF;
    ifc.clear_req = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_slot = '0;
    ifc.req_reg_addr = '0;
    ifc.req_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", ifc.req_ready, 1'b0);
    chk("rst_cyc", ifc.wb_cyc_o, 1'b0);
    chk("rst_stb", ifc.wb_stb_o, 1'b0);
    chk("rst_we", ifc.wb_we_o, 1'b0);
    chk("rst_adr", ifc.wb_adr_o, 8'h00);
    chk("rst_dat", ifc.wb_dat_o, 8'h00);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_err", ifc.err, 1'b0);
    reset = 1'b0;

    // 1: slot 0, 49h/C0h, latency 11
    base = log_n;
    send_rec("t1", 3'd0, 8'h49, 8'hC0);
    wait_flag(50, 1'b0, n);
    chk("t1_latency", n, 11);
    chk("t1_count", log_n - base, 5);
    chk_rec("t1", base, 8'h00, 8'h34, 8'h39, 8'h43, 8'h30);

    // 2: slot 7, 48h/18h, ready low while busy
    @(negedge clk);
    base = log_n;
    send_rec("t2", 3'd7, 8'h48, 8'h18);
    n = 0;
    rdy = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (ifc.done) break;
      if (ifc.req_ready) rdy++;
    end
    chk("t2_latency", n, 11);
    chk("t2_ready_low", rdy, 0);
    chk_rec("t2", base, 8'h1C, 8'h34, 8'h38, 8'h31, 8'h38);

    // 3: clear beats a pending record
    @(negedge clk);
    base = log_n;
    ifc.clear_req = 1'b1;
    ifc.req_slot = 3'd2;
    ifc.req_reg_addr = 8'hA5;
    ifc.req_data = 8'h3F;
    ifc.req_valid = 1'b1;
    #1;
    chk("t3_ready_prio", ifc.req_ready, 1'b0);
    @(negedge clk);
    ifc.clear_req = 1'b0;
    wait_flag(200, 1'b0, n);
    chk("t3_clr_latency", n, 67);
    chk("t3_clr_count", log_n - base, 33);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("t3_clr_adr%0d", k), log_adr[base+k], 8'(k));
      chk($sformatf("t3_clr_dat%0d", k), log_dat[base+k], 8'h20);
    end
    chk("t3_clr_rp_adr", log_adr[base+32], 8'h80);
    @(negedge clk);
    ifc.req_valid = 1'b0;
    wait_flag(50, 1'b0, n);
    chk("t3_rec_latency", n, 11);
    chk_rec("t3", base + 33, 8'h08, 8'h41, 8'h35, 8'h33, 8'h46);

    // 4: busy holds off the repaint
    @(negedge clk);
    busy = 1'b1;
    base = log_n;
    dbase = n_done;
    send_rec("t4", 3'd1, 8'h00, 8'hFF);
    n = 0;
    while (n < 50 && log_n - base < 4) begin
      @(negedge clk);
      n++;
    end
    repeat (100) @(negedge clk);
    chk("t4_no_repaint", log_n - base, 4);
    chk("t4_cyc_idle", ifc.wb_cyc_o, 1'b0);
    chk("t4_no_done", n_done - dbase, 0);
    busy = 1'b0;
    wait_flag(20, 1'b0, n);
    chk("t4_rp_latency", n, 3);
    chk_rec("t4", base, 8'h04, 8'h30, 8'h30, 8'h46, 8'h46);

    // 5: ack withheld on char 2 of slot 3
    @(negedge clk);
    nack_adr = 8'h0E;
    base = log_n;
    dbase = n_done;
    n_stall = 0;
    send_rec("t5", 3'd3, 8'h12, 8'h34);
    wait_flag(100, 1'b1, n);
    chk("t5_err_latency", n, 21);
    repeat (3) @(negedge clk);
    chk("t5_stall_cycles", n_stall, 16);
    chk("t5_err_pulses", n_errp, 1);
    chk("t5_no_done", n_done - dbase, 0);
    chk("t5_writes", log_n - base, 2);
    chk("t5_cyc_idle", ifc.wb_cyc_o, 1'b0);
    nack_adr = 8'hFF;
    base = log_n;
    send_rec("t5b", 3'd3, 8'h12, 8'h34);
    wait_flag(50, 1'b0, n);
    chk("t5b_latency", n, 11);
    chk_rec("t5b", base, 8'h0C, 8'h31, 8'h32, 8'h33, 8'h34);

    // 6: reset while waiting on char 1 of slot 5
    @(negedge clk);
    nack_adr = 8'h15;
    base = log_n;
    dbase = n_done;
    send_rec("t6", 3'd5, 8'h77, 8'h88);
    n = 0;
    while (n < 50 && !(ifc.wb_cyc_o && ifc.wb_adr_o == 8'h15)) begin
      @(negedge clk);
      n++;
    end
    chk("t6_stalled", ifc.wb_cyc_o, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_cyc", ifc.wb_cyc_o, 1'b0);
    chk("t6_stb", ifc.wb_stb_o, 1'b0);
    chk("t6_we", ifc.wb_we_o, 1'b0);
    chk("t6_adr", ifc.wb_adr_o, 8'h00);
    chk("t6_done", ifc.done, 1'b0);
    chk("t6_err", ifc.err, 1'b0);
    chk("t6_ready_in_rst", ifc.req_ready, 1'b0);
    reset = 1'b0;
    nack_adr = 8'hFF;
    #1;
    chk("t6_ready_after", ifc.req_ready, 1'b1);
    repeat (20) @(negedge clk);
    chk("t6_no_repaint", n_done - dbase, 0);
    chk("t6_writes", log_n - base, 1);
    base = log_n;
    send_rec("t6b", 3'd6, 8'h9B, 8'hE7);
    wait_flag(50, 1'b0, n);
    chk("t6b_latency", n, 11);
    chk_rec("t6b", base, 8'h18, 8'h39, 8'h42, 8'h45, 8'h37);

    $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
    $finish;
  end

endmodule
